irl_tb_mem: RTL and testbench
=============================

IRL_TB_MEM -- requirements
Module: irl_tb_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 32, entry width in bits.
REQ-002 SHALL have parameter DEPTH_NBITS, default 10, address width; 2**DEPTH_NBITS entries.
REQ-003 SHALL have parameter PEND_DEPTH, default 4, secondary-write pending queue entries (power of two, at least 2).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports rd  in  1 and raddr  in  DEPTH_NBITS: read strobe and address.
REQ-007 SHALL have ports ack  out  1 and rdata  out  WIDTH: read acknowledge and read data.
REQ-008 SHALL have ports pwr  in  1, pwaddr  in  DEPTH_NBITS and pwdata  in  WIDTH: primary (bucket updater) write.
REQ-009 SHALL have ports swr  in  1, swaddr  in  DEPTH_NBITS and swdata  in  WIDTH: secondary (control/ECDSA) write.
REQ-010 SHALL have port sfull  out  1: pending queue full.
REQ-011 SHALL have port pend_cnt  out  $clog2(PEND_DEPTH)+1: pending queue occupancy.
REQ-012 SHALL have port sdrop  out  1: one-cycle pulse when a secondary write is discarded.
REQ-013 SHALL have port drop_cnt  out  16: saturating count of discarded secondary writes.

Function
REQ-014 SHALL commit a primary write to the RAM in the cycle pwr is high, unconditionally.
REQ-015 SHALL enqueue each accepted secondary write into a FIFO of PEND_DEPTH entries, in arrival order.
REQ-016 SHALL drain the FIFO head to the RAM in any cycle where pwr is low and pend_cnt is nonzero, one entry per cycle.
REQ-017 SHALL accept swr in the same cycle as a drain when the FIFO is full, so the entry count stays PEND_DEPTH.
REQ-018 SHALL, on swr with the FIFO full and no drain that cycle, discard the write, pulse sdrop next cycle and increment drop_cnt, saturating at 16'hFFFF.
REQ-019 SHALL drive sfull high exactly when pend_cnt equals PEND_DEPTH; pend_cnt SHALL be registered and reflect all enqueues and drains up to the previous edge.
REQ-020 SHALL assert ack exactly one cycle after rd, with rdata valid in that same cycle; rd is accepted every cycle, with no backpressure.
REQ-021 SHALL, with forwarding compiled in, return for a read the value of the newest write to raddr, in this priority: same-cycle primary write, then same-cycle drain write, then the youngest matching FIFO entry not draining this cycle, then RAM contents.
REQ-022 SHALL NOT make a secondary write enqueued in the same cycle as rd visible to that read.
REQ-023 SHALL, after a primary write followed by an older pending secondary write to the same address draining later, leave the secondary value in RAM; ordering is by commit, not by issue.
REQ-024 SHALL hold rdata at its last value when ack is low.
REQ-025 SHALL compute FIFO pointers modulo PEND_DEPTH, with wrap-around transparent to ordering.

Reset
REQ-026 SHALL, on rst, clear ack, sdrop, rdata, pend_cnt, drop_cnt and the FIFO pointers to zero, and set sfull to 0.
REQ-027 SHALL discard pending FIFO entries on rst, even mid-drain; RAM contents SHALL NOT be initialised by reset.
REQ-028 SHALL ignore rd, pwr and swr in any cycle rst is high; no ack follows a read issued during reset.

Configuration
REQ-029 SHALL implement the read-forwarding of REQ-021 only when the macro IRL_TB_MEM_FWD_EN is defined.
REQ-030 SHALL, without IRL_TB_MEM_FWD_EN, return raw RAM contents with read-old-data on a same-cycle write and no FIFO lookup; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: pwr addr 5 data 0xA at cycle 0, rd addr 5 at cycle 1 -> ack at cycle 2 with rdata 0xA.
REQ-032 SHALL cover: pwr held high 6 cycles while swr issues 5 writes with PEND_DEPTH=4 -> 4 queued, sfull=1, one sdrop pulse, drop_cnt=1, then 4 drains in order after pwr drops.
REQ-033 SHALL cover, with FWD_EN: swr addr 7 data 0x11 then 0x22 queued behind pwr, then rd addr 7 -> rdata 0x22; without FWD_EN -> old RAM value.
REQ-034 SHALL cover: same-cycle pwr addr 3 data 0xB and rd addr 3 -> rdata 0xB with FWD_EN, prior value without it.
REQ-035 SHALL cover: rst asserted with pend_cnt=3 -> next cycle pend_cnt=0, no drain writes occur, ack=0.
REQ-036 SHALL cover: 70000 forced drops -> drop_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/irl_tb_mem_if.sv
// rtl/irl_tb_mem_if.sv - bus bundle for the irl_tb_mem table memory
//
// Purpose: groups the read port, primary write port, secondary write port
// and pending-queue status of irl_tb_mem into one interface.
// Parameters: WIDTH (entry bits), DEPTH_NBITS (address bits),
//             PEND_DEPTH (secondary pending queue entries).
// Signals:
//   rd, raddr                -> read strobe and address
//   ack, rdata               <- read acknowledge and data (one cycle later)
//   pwr, pwaddr, pwdata      -> primary write (always commits)
//   swr, swaddr, swdata      -> secondary write (queued)
//   sfull, pend_cnt          <- queue full flag and occupancy
//   sdrop, drop_cnt          <- discard pulse and saturating discard count
// Modports: master (drives requests), slave (the memory).
interface irl_tb_mem_if #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 10,
  parameter int PEND_DEPTH  = 4
);
  localparam int CW = $clog2(PEND_DEPTH) + 1;

  logic                   rd;
  logic [DEPTH_NBITS-1:0] raddr;
  logic                   ack;
  logic [WIDTH-1:0]       rdata;
  logic                   pwr;
  logic [DEPTH_NBITS-1:0] pwaddr;
  logic [WIDTH-1:0]       pwdata;
  logic                   swr;
  logic [DEPTH_NBITS-1:0] swaddr;
  logic [WIDTH-1:0]       swdata;
  logic                   sfull;
  logic [CW-1:0]          pend_cnt;
  logic                   sdrop;
  logic [15:0]            drop_cnt;

  modport master (
    output rd, raddr, pwr, pwaddr, pwdata, swr, swaddr, swdata,
    input  ack, rdata, sfull, pend_cnt, sdrop, drop_cnt
  );

  modport slave (
    input  rd, raddr, pwr, pwaddr, pwdata, swr, swaddr, swdata,
    output ack, rdata, sfull, pend_cnt, sdrop, drop_cnt
  );
endinterface

// File: rtl/irl_tb_mem.sv
// rtl/irl_tb_mem.sv - table memory with primary write port and queued secondary writes
//
// Purpose: single-write-port RAM of 2**DEPTH_NBITS entries. The primary
// (bucket updater) port always wins the write port; secondary
// (control/ECDSA) writes wait in a PEND_DEPTH-entry FIFO and drain one per
// cycle whenever the primary port is idle. Secondary writes arriving with
// the FIFO full and no drain in that cycle are discarded and counted.
// Reads are accepted every cycle and answered one cycle later.
//
// Optional feature: define IRL_TB_MEM_FWD_EN to forward the newest in-flight
// write (same-cycle primary, same-cycle drain, youngest queued entry) to a
// read. Without it, reads return RAM contents, old data on a same-cycle write.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset (clears control state, not RAM)
//   bus  - irl_tb_mem_if.slave: read, primary write, secondary write, status
module irl_tb_mem #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 10,
  parameter int PEND_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  irl_tb_mem_if.slave bus
);
  localparam int            PW       = $clog2(PEND_DEPTH);
  localparam int            CW       = PW + 1;
  localparam int            NENT     = 2 ** DEPTH_NBITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(PEND_DEPTH);

  logic [WIDTH-1:0]       mem       [NENT];
  logic [DEPTH_NBITS-1:0] pend_addr [PEND_DEPTH];
  logic [WIDTH-1:0]       pend_data [PEND_DEPTH];

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             ack_q;
  logic [WIDTH-1:0] rdata_q;
  logic             sdrop_q;
  logic [15:0]      drop_q;

  logic             full;
  logic             drain;
  logic             accept;
  logic             drop;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  // The primary port owns the RAM write port; the queue head only gets it
  // in cycles the primary port leaves free. Nothing moves during reset.
  assign full   = (cnt == FULL_CNT);
  assign drain  = !rst && !bus.pwr && (cnt != '0);
  // A full queue still accepts when its head leaves in the same cycle.
  assign accept = !rst && bus.swr && (!full || drain);
  assign drop   = !rst && bus.swr && full && !drain;

  // RAM write port, deliberately without reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.pwr) begin
        mem[bus.pwaddr] <= bus.pwdata;
      end else if (drain) begin
        mem[pend_addr[rptr]] <= pend_data[rptr];
      end
    end
  end

  // Queue storage; only the pointers and count need reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_addr[wptr] <= bus.swaddr;
      pend_data[wptr] <= bus.swdata;
    end
  end

`ifdef IRL_TB_MEM_FWD_EN
  // Later assignments override earlier ones, so the checks run from lowest
  // to highest priority: queued entries oldest-to-youngest, then the drain,
  // then the primary write. The head entry is skipped while it drains since
  // the drain check covers it. A write enqueued this cycle is not yet in the
  // valid range and so stays invisible to this read.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if ((CW'(i) < cnt) && !(i == 0 && drain) &&
          (pend_addr[rptr + PW'(i)] == bus.raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = pend_data[rptr + PW'(i)];
      end
    end
    if (drain && (pend_addr[rptr] == bus.raddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = pend_data[rptr];
    end
    if (bus.pwr && (bus.pwaddr == bus.raddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.pwdata;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Control state, read response and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      sdrop_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + PW'(1);
      end
      if (drain) begin
        rptr <= rptr + PW'(1);
      end
      case ({accept, drain})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      sdrop_q <= drop;
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end

      // The RAM read sees pre-edge contents, giving read-old-data when
      // forwarding is absent.
      ack_q <= bus.rd;
      if (bus.rd) begin
        rdata_q <= fwd_hit ? fwd_data : mem[bus.raddr];
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.sfull    = full;
  assign bus.pend_cnt = cnt;
  assign bus.sdrop    = sdrop_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_irl_tb_mem.sv
// tb/tb_irl_tb_mem.sv - directed self-checking bench for irl_tb_mem
module tb_irl_tb_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  irl_tb_mem_if #(.WIDTH(32), .DEPTH_NBITS(10), .PEND_DEPTH(4)) bif ();

  irl_tb_mem #(.WIDTH(32), .DEPTH_NBITS(10), .PEND_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.rd = 1'b0; bif.raddr = '0;
    bif.pwr = 1'b0; bif.pwaddr = '0; bif.pwdata = '0;
    bif.swr = 1'b0; bif.swaddr = '0; bif.swdata = '0;
  endtask

  task automatic pwrite(input logic [9:0] a, input logic [31:0] d);
    bif.pwr = 1'b1; bif.pwaddr = a; bif.pwdata = d;
    tick();
    bif.pwr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (bif.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0h expected 0", bif.ack); end
    n_checks++; if (bif.sdrop !== 1'b0) begin n_fail++; $display("FAIL reset_sdrop: got %0h expected 0", bif.sdrop); end
    n_checks++; if (bif.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", bif.rdata); end
    n_checks++; if (bif.pend_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_pend_cnt: got %0d expected 0", bif.pend_cnt); end
    n_checks++; if (bif.drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0h expected 0", bif.drop_cnt); end
    n_checks++; if (bif.sfull !== 1'b0) begin n_fail++; $display("FAIL reset_sfull: got %0h expected 0", bif.sfull); end
    rst = 1'b0;
  endtask

  task automatic test_basic_read();
    pwrite(10'd5, 32'hA);
    bif.rd = 1'b1; bif.raddr = 10'd5;
    tick();
    bif.rd = 1'b0;
    n_checks++; if (bif.ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %0h expected 1", bif.ack); end
    n_checks++; if (bif.rdata !== 32'hA) begin n_fail++; $display("FAIL basic_rdata: got %0h expected a", bif.rdata); end
    tick();
    n_checks++; if (bif.ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_low: got %0h expected 0", bif.ack); end
    n_checks++; if (bif.rdata !== 32'hA) begin n_fail++; $display("FAIL basic_rdata_hold: got %0h expected a", bif.rdata); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
`ifdef IRL_TB_MEM_FWD_EN
    exp = 32'hB;
`else
    exp = 32'h5;
`endif
    pwrite(10'd3, 32'h5);
    bif.pwr = 1'b1; bif.pwaddr = 10'd3; bif.pwdata = 32'hB;
    bif.rd = 1'b1; bif.raddr = 10'd3;
    tick();
    bif.pwr = 1'b0;
    n_checks++; if (bif.rdata !== exp) begin n_fail++; $display("FAIL same_cycle_rdata: got %0h expected %0h", bif.rdata, exp); end
    tick();
    bif.rd = 1'b0;
    n_checks++; if (bif.rdata !== 32'hB) begin n_fail++; $display("FAIL same_cycle_after: got %0h expected b", bif.rdata); end
  endtask

  task automatic test_queue_full();
    logic [9:0]  qa [5];
    logic [31:0] qd [5];
    logic [9:0]  ra [4];
    logic [31:0] rv [4];
    qa = '{10'd20, 10'd21, 10'd20, 10'd22, 10'd23};
    qd = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    ra = '{10'd20, 10'd21, 10'd22, 10'd23};
    rv = '{32'h3, 32'h2, 32'h4, 32'h77};
    pwrite(10'd23, 32'h77);
    bif.pwr = 1'b1; bif.pwaddr = 10'd100; bif.pwdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      bif.swr = 1'b1; bif.swaddr = qa[k]; bif.swdata = qd[k];
      tick();
    end
    bif.swr = 1'b0;
    n_checks++; if (bif.pend_cnt !== 3'd4) begin n_fail++; $display("FAIL full_pend_cnt: got %0d expected 4", bif.pend_cnt); end
    n_checks++; if (bif.sfull !== 1'b1) begin n_fail++; $display("FAIL full_sfull: got %0h expected 1", bif.sfull); end
    n_checks++; if (bif.sdrop !== 1'b1) begin n_fail++; $display("FAIL full_sdrop: got %0h expected 1", bif.sdrop); end
    n_checks++; if (bif.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_drop_cnt: got %0d expected 1", bif.drop_cnt); end
    tick();
    n_checks++; if (bif.sdrop !== 1'b0) begin n_fail++; $display("FAIL full_sdrop_pulse: got %0h expected 0", bif.sdrop); end
    n_checks++; if (bif.pend_cnt !== 3'd4) begin n_fail++; $display("FAIL full_hold_pwr: got %0d expected 4", bif.pend_cnt); end
    bif.pwr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bif.pend_cnt !== 3'(3 - k)) begin n_fail++; $display("FAIL drain_pend_cnt_%0d: got %0d expected %0d", k, bif.pend_cnt, 3 - k); end
    end
    n_checks++; if (bif.sfull !== 1'b0) begin n_fail++; $display("FAIL drain_sfull: got %0h expected 0", bif.sfull); end
    for (int k = 0; k < 4; k++) begin
      bif.rd = 1'b1; bif.raddr = ra[k];
      tick();
      n_checks++; if (bif.rdata !== rv[k]) begin n_fail++; $display("FAIL drain_order_%0d: got %0h expected %0h", k, bif.rdata, rv[k]); end
    end
    bif.rd = 1'b0;
  endtask

  task automatic test_forward_queue();
    logic [31:0] exp;
`ifdef IRL_TB_MEM_FWD_EN
    exp = 32'h22;
`else
    exp = 32'h5;
`endif
    pwrite(10'd7, 32'h5);
    pwrite(10'd8, 32'h44);
    bif.pwr = 1'b1; bif.pwaddr = 10'd100; bif.pwdata = 32'h0;
    bif.swr = 1'b1; bif.swaddr = 10'd7; bif.swdata = 32'h11;
    tick();
    bif.swdata = 32'h22;
    tick();
    bif.swr = 1'b0;
    bif.rd = 1'b1; bif.raddr = 10'd7;
    tick();
    n_checks++; if (bif.rdata !== exp) begin n_fail++; $display("FAIL fwd_queue_rdata: got %0h expected %0h", bif.rdata, exp); end
    // Secondary write enqueued in the same cycle as the read stays hidden.
    bif.swr = 1'b1; bif.swaddr = 10'd8; bif.swdata = 32'h33;
    bif.raddr = 10'd8;
    tick();
    bif.swr = 1'b0; bif.rd = 1'b0;
    n_checks++; if (bif.rdata !== 32'h44) begin n_fail++; $display("FAIL same_cycle_enqueue: got %0h expected 44", bif.rdata); end
    n_checks++; if (bif.pend_cnt !== 3'd3) begin n_fail++; $display("FAIL fwd_pend_cnt: got %0d expected 3", bif.pend_cnt); end
    bif.pwr = 1'b0;
    tick(); tick(); tick();
    bif.rd = 1'b1; bif.raddr = 10'd7;
    tick();
    n_checks++; if (bif.rdata !== 32'h22) begin n_fail++; $display("FAIL fwd_after_drain7: got %0h expected 22", bif.rdata); end
    bif.raddr = 10'd8;
    tick();
    bif.rd = 1'b0;
    n_checks++; if (bif.rdata !== 32'h33) begin n_fail++; $display("FAIL fwd_after_drain8: got %0h expected 33", bif.rdata); end
  endtask

  task automatic test_commit_order();
    bif.pwr = 1'b1; bif.pwaddr = 10'd100; bif.pwdata = 32'h0;
    bif.swr = 1'b1; bif.swaddr = 10'd9; bif.swdata = 32'h55;
    tick();
    bif.swr = 1'b0;
    bif.pwaddr = 10'd9; bif.pwdata = 32'h66;
    tick();
    bif.pwr = 1'b0;
    tick();
    n_checks++; if (bif.pend_cnt !== 3'd0) begin n_fail++; $display("FAIL order_pend_cnt: got %0d expected 0", bif.pend_cnt); end
    bif.rd = 1'b1; bif.raddr = 10'd9;
    tick();
    bif.rd = 1'b0;
    n_checks++; if (bif.rdata !== 32'h55) begin n_fail++; $display("FAIL order_commit: got %0h expected 55", bif.rdata); end
  endtask

  task automatic test_reset_mid();
    pwrite(10'd30, 32'h0);
    pwrite(10'd31, 32'h0);
    pwrite(10'd32, 32'h0);
    bif.pwr = 1'b1; bif.pwaddr = 10'd100; bif.pwdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      bif.swr = 1'b1; bif.swaddr = 10'(30 + k); bif.swdata = 32'(k + 1);
      tick();
    end
    bif.swr = 1'b0;
    n_checks++; if (bif.pend_cnt !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d expected 3", bif.pend_cnt); end
    bif.pwr = 1'b0;
    rst = 1'b1;
    bif.rd = 1'b1; bif.raddr = 10'd30;
    tick();
    rst = 1'b0;
    bif.rd = 1'b0;
    n_checks++; if (bif.pend_cnt !== 3'd0) begin n_fail++; $display("FAIL rstmid_pend_cnt: got %0d expected 0", bif.pend_cnt); end
    n_checks++; if (bif.ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %0h expected 0", bif.ack); end
    n_checks++; if (bif.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop_cnt: got %0d expected 0", bif.drop_cnt); end
    tick();
    n_checks++; if (bif.pend_cnt !== 3'd0) begin n_fail++; $display("FAIL rstmid_no_drain_cnt: got %0d expected 0", bif.pend_cnt); end
    for (int k = 0; k < 3; k++) begin
      bif.rd = 1'b1; bif.raddr = 10'(30 + k);
      tick();
      n_checks++; if (bif.rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_ram_%0d: got %0h expected 0", k, bif.rdata); end
    end
    bif.rd = 1'b0;
  endtask

  task automatic test_drop_saturate();
    bif.pwr = 1'b1; bif.pwaddr = 10'd100; bif.pwdata = 32'h0;
    bif.swr = 1'b1; bif.swaddr = 10'd40; bif.swdata = 32'h99;
    // First four cycles fill the queue; every later cycle is a drop.
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (k == 103) begin
        n_checks++; if (bif.drop_cnt !== 16'd100) begin n_fail++; $display("FAIL sat_count_100: got %0d expected 100", bif.drop_cnt); end
      end
      if (k == 65537) begin
        n_checks++; if (bif.drop_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_count_fffe: got %0h expected fffe", bif.drop_cnt); end
      end
    end
    bif.swr = 1'b0;
    n_checks++; if (bif.drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count_ffff: got %0h expected ffff", bif.drop_cnt); end
    n_checks++; if (bif.sdrop !== 1'b1) begin n_fail++; $display("FAIL sat_sdrop: got %0h expected 1", bif.sdrop); end
    n_checks++; if (bif.pend_cnt !== 3'd4) begin n_fail++; $display("FAIL sat_pend_cnt: got %0d expected 4", bif.pend_cnt); end
    bif.pwr = 1'b0;
    tick(); tick(); tick(); tick();
    n_checks++; if (bif.pend_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_drained: got %0d expected 0", bif.pend_cnt); end
    n_checks++; if (bif.drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h expected ffff", bif.drop_cnt); end
    bif.rd = 1'b1; bif.raddr = 10'd40;
    tick();
    bif.rd = 1'b0;
    n_checks++; if (bif.rdata !== 32'h99) begin n_fail++; $display("FAIL sat_ram: got %0h expected 99", bif.rdata); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_read();
    test_same_cycle();
    test_queue_full();
    test_forward_queue();
    test_commit_order();
    test_reset_mid();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
